// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - AES-128 key expansion streamed byte-wise into a key memory
// Optional macro AES_KEY_SCHED_STALL_EN adds wr_ready back-pressure on the write port.
module aes_key_sched #(
   parameter int ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
`ifdef AES_KEY_SCHED_STALL_EN
   input  logic         wr_ready,
`endif
   output logic         busy,
   output logic         done,
   output logic         wr_en,
   output logic [7:0]   wr_addr,
   output logic [7:0]   wr_data
);

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX[{~a, 3'b111} -: 8];
   endfunction

   typedef enum logic [2:0] {IDLE, LOAD, GEN, WRITE, DONE} state_t;

   state_t       state, state_nx;
   logic [127:0] window;
   logic [3:0]   round;
   logic [4:0]   cnt;
   logic [7:0]   next_addr;
   logic         consume;
   logic         can_issue;
   logic [7:0]   rcon;
   logic [31:0]  w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

`ifdef AES_KEY_SCHED_STALL_EN
   assign consume = wr_en & wr_ready;
`else
   assign consume = wr_en;
`endif
   // A new byte may be presented once the write port is empty or its byte is taken.
   assign can_issue = ~wr_en | consume;

   assign {w0, w1, w2, w3} = window;
   assign rot = {w3[23:0], w3[31:24]};
   assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
   assign n0  = w0 ^ sub ^ {rcon, 24'h0};
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;

   // round holds the number of round keys already produced, so Rcon is for round+1.
   always_comb begin
      rcon = 8'h00;
      case (round)
         4'd0: rcon = 8'h01;
         4'd1: rcon = 8'h02;
         4'd2: rcon = 8'h04;
         4'd3: rcon = 8'h08;
         4'd4: rcon = 8'h10;
         4'd5: rcon = 8'h20;
         4'd6: rcon = 8'h40;
         4'd7: rcon = 8'h80;
         4'd8: rcon = 8'h1b;
         4'd9: rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = LOAD;
         LOAD, WRITE: begin
            busy = 1'b1;
            if (can_issue && cnt == 5'd16)
               state_nx = (round < LAST_ROUND) ? GEN : DONE;
         end
         GEN: begin
            busy     = 1'b1;
            state_nx = WRITE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         window    <= '0;
         round     <= '0;
         cnt       <= '0;
         next_addr <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start) begin
               window    <= key;
               round     <= '0;
               cnt       <= '0;
               next_addr <= '0;
               wr_addr   <= '0;
            end
            LOAD, WRITE: if (can_issue) begin
               if (cnt == 5'd16) begin
                  wr_en <= 1'b0;
                  cnt   <= '0;
               end else begin
                  wr_en     <= 1'b1;
                  wr_addr   <= next_addr;
                  wr_data   <= window[{~cnt[3:0], 3'b111} -: 8];
                  next_addr <= next_addr + 8'd1;
                  cnt       <= cnt + 5'd1;
               end
            end
            // The exit edge of GEN already presents byte 0 of the new round key.
            GEN: begin
               window    <= {n0, n1, n2, n3};
               round     <= round + 4'd1;
               wr_en     <= 1'b1;
               wr_addr   <= next_addr;
               wr_data   <= n0[31:24];
               next_addr <= next_addr + 8'd1;
               cnt       <= 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_sched.sv
// tb/tb_aes_key_sched.sv - scoreboard bench for aes_key_sched against a GF(2^8) key-expansion model
`timescale 1ns/1ps
module tb_aes_key_sched;
   localparam int ROUNDS = 10;
   localparam int NBYTES = 16 * (ROUNDS + 1);
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] key = '0;
   logic         wr_ready = 1'b1;
   logic         busy, done, wr_en;
   logic [7:0]   wr_addr, wr_data;

   int n_checks = 0, n_fail = 0;
   int cyc = 0, e0 = 0, stall_extra = 0;
   int n_wr = 0, n_done = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  mem [0:255];
   logic [7:0]  sbox [0:255];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   aes_key_sched #(.ROUNDS(ROUNDS)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .key(key),
`ifdef AES_KEY_SCHED_STALL_EN
      .wr_ready(wr_ready),
`endif
      .busy(busy),
      .done(done),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   // S-box from first principles: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic push_expected(input logic [127:0] k);
      logic [31:0] w [0:4*(ROUNDS+1)-1];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 4 * (ROUNDS + 1); i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < NBYTES; i++) exp_q.push_back({8'(i), w[i/4][31-8*(i%4) -: 8]});
   endtask

   function automatic logic [31:0] get32(input int a);
      return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
   endfunction

   always @(negedge clk) if (rst_n) begin
      if (wr_en && wr_ready) begin
         if (n_wr == 0) check("first_write_cycle", cyc - e0, 1);
         n_wr++;
         mem[wr_addr] = wr_data;
         if (exp_q.size() == 0) check("unexpected_write", {wr_addr, wr_data}, 0);
         else check("write_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
      end
      if (done) begin
         n_done++;
         check("done_busy_low", busy, 0);
         check("done_wr_en_low", wr_en, 0);
      end
   end

`ifdef AES_KEY_SCHED_STALL_EN
   bit         stall_arm = 1'b0;
   int         stall_cnt = 0;
   logic [7:0] held_data = '0;
   always @(posedge clk) begin
      #1;
      if (stall_cnt > 0) begin
         check("stall_hold", {wr_en, wr_addr, wr_data}, {1'b1, 8'd20, held_data});
         stall_cnt--;
         if (stall_cnt == 0) wr_ready = 1'b1;
      end else if (stall_arm && wr_en && wr_addr == 8'd20) begin
         stall_arm = 1'b0;
         stall_cnt = 5;
         held_data = wr_data;
         wr_ready  = 1'b0;
      end
   end
`endif

   task automatic begin_run(input logic [127:0] k);
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      exp_q.delete();
      push_expected(k);
      n_wr = 0;
      n_done = 0;
      @(negedge clk);
      key = k;
      start = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      start = 1'b0;
      key = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic run(input logic [127:0] k, input bit restart_mid);
      int dc = -1;
      begin_run(k);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start = (restart_mid && cyc - e0 == 49);
         if (restart_mid && cyc - e0 == 49) key = ~key;
         if (done) begin
            dc = cyc - e0;
            break;
         end
      end
      check("done_cycle", dc, 17 * (ROUNDS + 1) + stall_extra);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", busy, 0);
      @(negedge clk);
      check("idle_after_done", {busy, done, wr_en}, 0);
      check("write_count", n_wr, NBYTES);
      check("queue_empty", exp_q.size(), 0);
      check("single_done", n_done, 1);
   endtask

   initial begin
      bit found = 1'b0;
      build_sbox();
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, wr_en, wr_addr, wr_data}, 0);
      rst_n = 1'b1;

      run(K1, 1'b0);
      check("k1_round1", get32(16), 32'hd6aa74fd);
      check("k1_round10", get32(160), 32'h13111d7f);
      check("k1_last", mem[175], 8'hc5);

      run(K2, 1'b0);
      check("k2_round1", get32(16), 32'ha0fafe17);
      check("k2_round10", {get32(160), get32(164), get32(168), get32(172)},
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run(K1, 1'b1);

      begin_run({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (wr_en && wr_addr == 8'd100) found = 1'b1;
      end
      check("reached_addr_100", found, 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", {busy, done, wr_en, wr_addr, wr_data}, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("no_done_on_reset", n_done, 0);
      rst_n = 1'b1;
      run({$urandom, $urandom, $urandom, $urandom}, 1'b0);

      for (int n = 0; n < 3; n++) run({$urandom, $urandom, $urandom, $urandom}, 1'b0);

`ifdef AES_KEY_SCHED_STALL_EN
      stall_extra = 5;
      stall_arm = 1'b1;
      run(K1, 1'b0);
      check("stall_k1_last", mem[175], 8'hc5);
      stall_extra = 0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
